// File: rtl/la_cellbist3_if.sv
// Cell self-test bus: run control and status toward the requester, stimulus and
// response toward the 3-input cell under test.
interface la_cellbist3_if;
  logic       start;
  logic [2:0] stim;
  logic       resp;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] fail_vec;

  // The requester side also provides the cell response.
  modport master (
    output start, resp,
    input  stim, busy, done, pass, fail_vec
  );

  modport slave (
    input  start, resp,
    output stim, busy, done, pass, fail_vec
  );
endinterface

// File: rtl/la_cellbist3.sv
// Exhaustive 3-input cell self-test: walks all eight vectors, checks them against TRUTH,
// and reports a failure map. Optional feature macro: LA_CELLBIST_STICKY_EN (accumulate fail_vec across runs).
module la_cellbist3 #(
  parameter logic [7:0] TRUTH  = 8'hF8,
  parameter int         SETTLE = 2,
  parameter             PROP   = "DEFAULT"
) (
  input logic          clk,
  input logic          rst,
  la_cellbist3_if.slave bus
);

  localparam int CW = $clog2(SETTLE + 1);
  localparam logic [CW-1:0] CNT_ZERO   = CW'(0);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t        state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [2:0]    stim_r, stim_s;
  logic [7:0]    fail_r, fail_s;
  logic          pass_r, pass_s;
  logic          busy_r, done_r;
  logic          mismatch_s;

  // Next-state and datapath update for the vector walk.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    stim_s     = stim_r;
    fail_s     = fail_r;
    pass_s     = pass_r;
    mismatch_s = (bus.resp != TRUTH[stim_r]);
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          state_s = ST_DRIVE;
          stim_s  = 3'd0;
          cnt_s   = CNT_ZERO;
`ifdef LA_CELLBIST_STICKY_EN
          fail_s  = fail_r;
`else
          fail_s  = 8'h00;
`endif
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_DRIVE: begin
        if (cnt_r == SETTLE_LAST) begin
          state_s = ST_SAMPLE;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_SAMPLE: begin
        if (mismatch_s) begin
          fail_s = fail_r | (8'h01 << stim_r);
        end else begin
          fail_s = fail_r;
        end
        // pass must include the final vector's result, so it is derived from fail_s.
        if (stim_r == 3'd7) begin
          state_s = ST_DONE;
          pass_s  = ~|fail_s;
        end else begin
          state_s = ST_DRIVE;
          stim_s  = stim_r + 3'd1;
          cnt_s   = CNT_ZERO;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
      stim_r  <= 3'd0;
      fail_r  <= 8'h00;
      pass_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      stim_r  <= stim_s;
      fail_r  <= fail_s;
      pass_r  <= pass_s;
      busy_r  <= (state_s == ST_DRIVE) || (state_s == ST_SAMPLE);
      done_r  <= (state_s == ST_DONE);
    end
  end

  assign bus.stim     = stim_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.pass     = pass_r;
  assign bus.fail_vec = fail_r;

endmodule
